rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the single register-file write port (EnRW/WN/WD) between two writeback requesters: the ALU writeback path (A) and the memory/load writeback path (M). Arbitration is round-robin, the port drive is registered, and a 16-entry pending-write scoreboard tells decode which registers still have a write in flight. It sits between the execute/memory stages and the RegisterFile write port. Its pending mask feeds the hazard/stall logic in decode.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 4, register index width (2**ADDR_W registers)

Ports:
- clk  in  1  single clock; all state updates on posedge clk
- rst  in  1  reset, synchronous, active-high
- a_valid  in  1  ALU requester has a write
- a_ready  out  1  ALU write accepted this cycle
- a_wn  in  ADDR_W  ALU destination register
- a_wd  in  DATA_W  ALU write data
- m_valid  in  1  memory requester has a write
- m_ready  out  1  memory write accepted this cycle
- m_wn  in  ADDR_W  memory destination register
- m_wd  in  DATA_W  memory write data
- iss_valid  in  1  decode issues an instruction that will write iss_wn
- iss_wn  in  ADDR_W  destination register of the issued instruction
- rf_EnRW  out  1  drives RegisterFile EnRW
- rf_WN  out  ADDR_W  drives RegisterFile WN
- rf_WD  out  DATA_W  drives RegisterFile WD
- rf_gnt_m  out  1  registered: current port write came from M
- pend_mask  out  2**ADDR_W  bit r = write to register r outstanding

## Operation
- Handshake: a transfer occurs in a cycle where valid && ready. The requester holds wn/wd stable until accepted. At most one of a_ready/m_ready is high in any cycle.
- ready is combinational from both valids and the rr pointer:
  - only one valid: that requester gets ready=1.
  - both valid: the requester that did not win the last contested grant gets ready=1.
  - rr toggles only on contested grants. After reset, A wins the first contest.
- The port is always free. The RegisterFile accepts one write per cycle, so there is no backpressure from the port and a winner is granted every cycle any valid is high.
- Output stage (registered):
  - On acceptance: rf_WN/rf_WD load the winner's values, rf_gnt_m = winner is M, rf_EnRW = (wn != 0).
  - No acceptance: rf_EnRW=0. rf_WN, rf_WD and rf_gnt_m hold their values.
- Register 0: a write with wn=0 is accepted normally (handshake completes) but produces rf_EnRW=0.
- Both requesters targeting the same register: the writes commit in grant order. The later grant's data is final.
- Scoreboard, pend_mask:
  - set: iss_valid && iss_wn != 0 sets bit iss_wn.
  - clear: rf_EnRW=1 clears bit rf_WN at the posedge ending the cycle in which the port is driven.
  - Set and clear of the same bit on the same edge: set wins (a newer producer has issued).
  - Bit 0 is constant 0.
  - Setting a bit that is already set leaves it set. One bit per register; decode must not issue a second writer to a register whose bit is already pending.

## Timing
- Acceptance in cycle N, then rf_EnRW/rf_WN/rf_WD are valid throughout cycle N+1.
- The RegisterFile commits at the negedge inside N+1.
- The pend bit reads 0 from cycle N+2, after the data is architecturally visible.
- Issue in cycle N, then the pend bit reads 1 from cycle N+1.
- Throughput: one write per cycle. A continuously valid requester under contention waits at most 1 cycle.
- Reset values: rf_EnRW=0, rf_WN=0, rf_WD=0, rf_gnt_m=0, pend_mask=0, rr -> A preferred. a_ready/m_ready still follow the valids combinationally.
- rst asserted mid-operation:
  - the in-flight output-stage write is dropped (rf_EnRW=0 in the next cycle).
  - pending bits clear.
  - requests presented while rst is high are not accepted: ready is forced 0 during rst.

## Structure
- Shared package cpu_pkg holds:
  - constants REG_DATA_W=32, REG_ADDR_W=4, NUM_REGS=16
  - enum wb_src_t {WB_ALU, WB_MEM}, used for rf_gnt_m decoding by the debug/trace logic.
- Natural sub-module: rf_scoreboard, holding pend_mask with its set/clear ports and the same-edge priority rule. The arbiter and output stage stay in the top module.

## Test plan
- Single requester: A writes r5=0x00045432 in cycle 2. Expect a_ready=1 in cycle 2, rf_EnRW=1/rf_WN=5/rf_WD=0x00045432 in cycle 3, and RD of r5 = 0x00045432 after the negedge of cycle 3.
- Contention: A (r1=0x11) and M (r2=0x22) held valid for 4 cycles from reset. Expect grants A, M, A, M. rr toggles each cycle and neither requester waits more than 1 cycle.
- r0 write: M writes wn=0, wd=0xFFFFFFFF. Expect m_ready=1 and rf_EnRW=0 next cycle; RD of r0 stays 0.
- Scoreboard: iss r7 in cycle 1, giving pend_mask[7]=1 from cycle 2. A writes r7 in cycle 4, so the bit is still 1 in cycle 5 and reads 0 in cycle 6. Also issue r7 again in cycle 5 (same edge as the clear): the bit must stay 1.
- Same destination: A and M both write r4 (A=0xA, M=0xB) in the same cycle with rr=A. Expect r4 = 0xB after both commits, in grant order A then M.
- Reset mid-flight: accept an A write to r9, then assert rst on the next cycle. Expect rf_EnRW=0, pend_mask=0, a_ready=0 while rst=1, and r9 unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and writeback-source encoding used by the register-file
// write path and its debug/trace consumers.
package cpu_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_t;

endpackage

// File: rtl/rf_write_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared when the register file port commits the write.
module rf_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_i,
    input  logic [ADDR_W-1:0]    set_idx_i,
    input  logic                 clr_i,
    input  logic [ADDR_W-1:0]    clr_idx_i,
    output logic [2**ADDR_W-1:0] pend_o
);

    logic [2**ADDR_W-1:0] pend_q, pend_d;

    // Set is applied after clear so a newly issued producer survives a
    // same-edge commit of the older write.
    always_comb begin
        pend_d = pend_q;
        if (clr_i) pend_d[clr_idx_i] = 1'b0;
        if (set_i) pend_d[set_idx_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between the
// ALU and memory writeback paths, with a registered port drive.
module rf_write_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_W-1:0]    a_wn,
    input  logic [DATA_W-1:0]    a_wd,
    input  logic                 m_valid,
    output logic                 m_ready,
    input  logic [ADDR_W-1:0]    m_wn,
    input  logic [DATA_W-1:0]    m_wd,
    input  logic                 iss_valid,
    input  logic [ADDR_W-1:0]    iss_wn,
    output logic                 rf_EnRW,
    output logic [ADDR_W-1:0]    rf_WN,
    output logic [DATA_W-1:0]    rf_WD,
    output logic                 rf_gnt_m,
    output logic [2**ADDR_W-1:0] pend_mask
);

    // rr_q = 1 means A won the last contest, so M is preferred next time.
    logic              rr_q, rr_d;
    logic              a_win, m_win, contested;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] wn_q, wn_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    wb_src_t           src_q, src_d;

    always_comb begin
        contested = a_valid && m_valid;
        a_win     = !rst && a_valid && (!m_valid || !rr_q);
        m_win     = !rst && m_valid && (!a_valid || rr_q);
    end

    assign a_ready = a_win;
    assign m_ready = m_win;

    always_comb begin
        rr_d  = rr_q;
        en_d  = 1'b0;
        wn_d  = wn_q;
        wd_d  = wd_q;
        src_d = src_q;
        if (contested) rr_d = !rr_q;
        if (a_win) begin
            en_d  = (a_wn != '0);
            wn_d  = a_wn;
            wd_d  = a_wd;
            src_d = WB_ALU;
        end else if (m_win) begin
            en_d  = (m_wn != '0);
            wn_d  = m_wn;
            wd_d  = m_wd;
            src_d = WB_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q  <= 1'b0;
            en_q  <= 1'b0;
            wn_q  <= '0;
            wd_q  <= '0;
            src_q <= WB_ALU;
        end else begin
            rr_q  <= rr_d;
            en_q  <= en_d;
            wn_q  <= wn_d;
            wd_q  <= wd_d;
            src_q <= src_d;
        end
    end

    // Reset kills a write already sitting in the output stage before the
    // register file can commit it at the following negedge.
    assign rf_EnRW  = en_q && !rst;
    assign rf_WN    = wn_q;
    assign rf_WD    = wd_q;
    assign rf_gnt_m = (src_q == WB_MEM);

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_i     (iss_valid && (iss_wn != '0)),
        .set_idx_i (iss_wn),
        .clr_i     (rf_EnRW),
        .clr_idx_i (rf_WN),
        .pend_o    (pend_mask)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a reference arbiter predicts each port
// drive, a negedge monitor compares it, and a register-file model commits it.
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0, m_valid = 1'b0, iss_valid = 1'b0;
    logic [AW-1:0] a_wn = '0, m_wn = '0, iss_wn = '0;
    logic [DW-1:0] a_wd = '0, m_wd = '0;
    logic          a_ready, m_ready, rf_EnRW, rf_gnt_m;
    logic [AW-1:0] rf_WN;
    logic [DW-1:0] rf_WD;
    logic [NR-1:0] pend_mask;

    rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_wn(a_wn), .a_wd(a_wd),
        .m_valid(m_valid), .m_ready(m_ready), .m_wn(m_wn), .m_wd(m_wd),
        .iss_valid(iss_valid), .iss_wn(iss_wn),
        .rf_EnRW(rf_EnRW), .rf_WN(rf_WN), .rf_WD(rf_WD), .rf_gnt_m(rf_gnt_m),
        .pend_mask(pend_mask)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic [AW-1:0] wn;
        logic [DW-1:0] wd;
        logic          gm;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    int            tests_run = 0;
    int            tests_failed = 0;
    int            cyc = 0;
    bit            tb_rr = 1'b0;
    logic [DW-1:0] rf_model [NR] = '{default: '0};

    initial forever @(posedge clk) cyc++;

    // Register file: commits at the negedge inside the cycle the port is driven.
    initial forever @(negedge clk)
        if (rf_EnRW === 1'b1 && rf_WN != '0) rf_model[rf_WN] = rf_WD;

    // Port monitor: a due entry must match exactly, otherwise the port is idle.
    initial begin
        exp_t e;
        forever @(negedge clk) begin
            if (cyc > 0) begin
                if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    tests_run++;
                    if ({rf_EnRW, rf_WN, rf_WD, rf_gnt_m} !== {e.en, e.wn, e.wd, e.gm}) begin
                        tests_failed++;
                        $display("FAIL port_drive cyc=%0d got en=%b wn=%0d wd=%h gm=%b want en=%b wn=%0d wd=%h gm=%b",
                                 cyc, rf_EnRW, rf_WN, rf_WD, rf_gnt_m, e.en, e.wn, e.wd, e.gm);
                    end
                end else begin
                    tests_run++;
                    if (rf_EnRW !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL port_idle cyc=%0d got EnRW=%b want 0", cyc, rf_EnRW);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives both requesters for the current cycle and predicts the winner.
    task automatic drive(input bit av, input logic [AW-1:0] awn, input logic [DW-1:0] awd,
                         input bit mv, input logic [AW-1:0] mwn, input logic [DW-1:0] mwd,
                         output bit ea, output bit em);
        exp_t e;
        a_valid = av; a_wn = awn; a_wd = awd;
        m_valid = mv; m_wn = mwn; m_wd = mwd;
        ea = !rst && av && (!mv || !tb_rr);
        em = !rst && mv && (!av || tb_rr);
        if (rst)           tb_rr = 1'b0;
        else if (av && mv) tb_rr = !tb_rr;
        if (ea || em) begin
            e.wn  = ea ? awn : mwn;
            e.wd  = ea ? awd : mwd;
            e.en  = (e.wn != '0);
            e.gm  = em;
            e.due = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset;
        bit ea, em;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, ea, em);
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        bit ea, em;
        rst = 1'b1;
        drive(1, 3, 32'h33, 1, 6, 32'h66, ea, em);
        tick;
        tick;
        #1;
        tests_run++;
        if ({a_ready, m_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_ready got %b%b want 00", a_ready, m_ready);
        end
        tests_run++;
        if ({rf_EnRW, rf_WN, rf_WD, rf_gnt_m} !== '0) begin
            tests_failed++;
            $display("FAIL reset_port got en=%b wn=%0d wd=%h gm=%b want all 0", rf_EnRW, rf_WN, rf_WD, rf_gnt_m);
        end
        tests_run++;
        if (pend_mask !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_pend got %h want 0000", pend_mask);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, ea, em);
        tick;
    endtask

    task automatic test_single;
        bit ea, em;
        drive(1, 5, 32'h00045432, 0, 0, 0, ea, em);
        #1;
        tests_run++;
        if ({a_ready, m_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_ready got %b%b want 10", a_ready, m_ready);
        end
        tick;
        drive(0, 0, 0, 0, 0, 0, ea, em);
        tick;
        tests_run++;
        if (rf_model[5] !== 32'h00045432) begin
            tests_failed++;
            $display("FAIL single_rd5 got %h want 00045432", rf_model[5]);
        end
    endtask

    task automatic test_contention;
        bit ea, em;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h11, 1, 2, 32'h22, ea, em);
            #1;
            tests_run++;
            if ({a_ready, m_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                tests_failed++;
                $display("FAIL contention_grant%0d got %b%b want %s", i, a_ready, m_ready, (i % 2 == 0) ? "A" : "M");
            end
            tick;
        end
        drive(0, 0, 0, 0, 0, 0, ea, em);
        tick;
        tests_run++;
        if (rf_model[1] !== 32'h11 || rf_model[2] !== 32'h22) begin
            tests_failed++;
            $display("FAIL contention_rd got r1=%h r2=%h want 11 22", rf_model[1], rf_model[2]);
        end
    endtask

    task automatic test_r0;
        bit ea, em;
        drive(0, 0, 0, 1, 0, 32'hFFFFFFFF, ea, em);
        #1;
        tests_run++;
        if ({a_ready, m_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL r0_ready got %b%b want 01", a_ready, m_ready);
        end
        tick;
        drive(0, 0, 0, 0, 0, 0, ea, em);
        tick;
        tests_run++;
        if (rf_model[0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL r0_rd got %h want 0", rf_model[0]);
        end
    endtask

    task automatic test_scoreboard;
        bit ea, em;
        iss_valid = 1'b1; iss_wn = 4'd0;
        tick;
        iss_wn = 4'd7;
        tick;
        iss_valid = 1'b0;
        #1;
        tests_run++;
        if (pend_mask !== 16'h0080) begin
            tests_failed++;
            $display("FAIL sb_set got %h want 0080", pend_mask);
        end
        tick;
        tick;
        drive(1, 7, 32'h77, 0, 0, 0, ea, em);
        tick;
        drive(0, 0, 0, 0, 0, 0, ea, em);
        #1;
        tests_run++;
        if (pend_mask !== 16'h0080) begin
            tests_failed++;
            $display("FAIL sb_hold got %h want 0080", pend_mask);
        end
        tick;
        tests_run++;
        if (pend_mask !== 16'h0000) begin
            tests_failed++;
            $display("FAIL sb_clear got %h want 0000", pend_mask);
        end
        // Reissue r7 on the same edge that clears the older write.
        iss_valid = 1'b1; iss_wn = 4'd7;
        tick;
        iss_valid = 1'b0;
        drive(1, 7, 32'h78, 0, 0, 0, ea, em);
        tick;
        drive(0, 0, 0, 0, 0, 0, ea, em);
        iss_valid = 1'b1; iss_wn = 4'd7;
        tick;
        iss_valid = 1'b0;
        #1;
        tests_run++;
        if (pend_mask !== 16'h0080) begin
            tests_failed++;
            $display("FAIL sb_set_wins got %h want 0080", pend_mask);
        end
        drive(1, 7, 32'h79, 0, 0, 0, ea, em);
        tick;
        drive(0, 0, 0, 0, 0, 0, ea, em);
        tick;
        tests_run++;
        if (pend_mask !== 16'h0000 || rf_model[7] !== 32'h79) begin
            tests_failed++;
            $display("FAIL sb_final got pend=%h r7=%h want 0000 79", pend_mask, rf_model[7]);
        end
    endtask

    task automatic test_same_dest;
        bit ea, em;
        do_reset();
        drive(1, 4, 32'hA, 1, 4, 32'hB, ea, em);
        #1;
        tests_run++;
        if ({a_ready, m_ready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL same_dest_first got %b%b want 10", a_ready, m_ready);
        end
        tick;
        drive(0, 0, 0, 1, 4, 32'hB, ea, em);
        #1;
        tests_run++;
        if ({a_ready, m_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL same_dest_second got %b%b want 01", a_ready, m_ready);
        end
        tick;
        drive(0, 0, 0, 0, 0, 0, ea, em);
        tick;
        tests_run++;
        if (rf_model[4] !== 32'hB) begin
            tests_failed++;
            $display("FAIL same_dest_rd4 got %h want 0000000b", rf_model[4]);
        end
    endtask

    task automatic test_reset_midflight;
        bit ea, em;
        exp_t e;
        iss_valid = 1'b1; iss_wn = 4'd9;
        tick;
        iss_valid = 1'b0;
        drive(1, 9, 32'h99, 0, 0, 0, ea, em);
        tick;
        // The accepted write is dropped: port keeps WN/WD but EnRW is killed.
        e = exp_q.pop_front();
        e.en = 1'b0;
        exp_q.push_front(e);
        rst = 1'b1;
        drive(1, 9, 32'h1234, 0, 0, 0, ea, em);
        #1;
        tests_run++;
        if (a_ready !== 1'b0 || rf_EnRW !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_gate got a_ready=%b EnRW=%b want 0 0", a_ready, rf_EnRW);
        end
        tick;
        tests_run++;
        if (pend_mask !== 16'h0000 || {rf_WN, rf_WD, rf_gnt_m} !== '0) begin
            tests_failed++;
            $display("FAIL midrst_state got pend=%h wn=%0d wd=%h gm=%b want 0", pend_mask, rf_WN, rf_WD, rf_gnt_m);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, ea, em);
        tick;
        tick;
        tests_run++;
        if (rf_model[9] !== 32'h0) begin
            tests_failed++;
            $display("FAIL midrst_rd9 got %h want 0", rf_model[9]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_r0();
        test_scoreboard();
        test_same_dest();
        test_reset_midflight();
        tick;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL leftover_expect got %0d entries want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
